alu_result_stage: RTL and testbench

- Consumer end of the execute ALU interface.
- Captures each ALU result (output_data, zero, ALU_control) with its writeback and branch metadata into a registered 2-entry buffer.
- Converts the raw ALU result into a writeback value and a branch-taken decision, then presents both to the writeback/fetch side through a valid/ready handshake.
- Sits between EX and WB in the pipelined core.

---
 rtl/alu_result_stage.sv | 153 +++++++++++++++
 tb/tb_alu_result_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - EX->WB ALU result buffer: 2-entry FIFO with writeback/branch conversion.
// Optional pop statistics counters enabled by ALU_RESULT_STAGE_STATS_EN.
`ifndef ALU_DATA_WIDTH
`define ALU_DATA_WIDTH 32
`endif
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`endif
`ifndef ALU_LT
`define ALU_LT 4'd7
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd6
`endif

module alu_result_stage #(
    parameter int                    DATA_WIDTH = `ALU_DATA_WIDTH,
    parameter int                    CTRL_WIDTH = `ALU_CONTROL_WIDTH,
    parameter logic [CTRL_WIDTH-1:0] LT_CODE    = `ALU_LT,
    parameter logic [CTRL_WIDTH-1:0] SUB_CODE   = `ALU_SUB
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  alu_zero,
    input  logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [4:0]            rd,
    input  logic                  reg_write,
    input  logic [1:0]            br_type,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_en,
`ifdef ALU_RESULT_STAGE_STATS_EN
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_taken,
`endif
    output logic                  br_taken
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [4:0]            rd;
        logic                  en;
        logic                  br;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    entry_t     new_entry;
    entry_t     head;
    logic       rptr_q, rptr_d;
    logic       wptr_q, wptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // The ALU LT op yields 0 when a<b, so invert bit 0 to get standard SLT.
    always_comb begin
        new_entry      = '0;
        new_entry.data = (alu_ctrl == LT_CODE) ? {{(DATA_WIDTH-1){1'b0}}, ~alu_data[0]} : alu_data;
        new_entry.rd   = rd;
        new_entry.en   = reg_write && (rd != 5'd0);
        case (br_type)
            2'b01:   new_entry.br = (alu_ctrl == SUB_CODE) && alu_zero;
            2'b10:   new_entry.br = (alu_ctrl == SUB_CODE) && !alu_zero;
            2'b11:   new_entry.br = (alu_ctrl == LT_CODE) && !alu_data[0];
            default: new_entry.br = 1'b0;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = 1'b0;
            wptr_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = new_entry;
                wptr_d        = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head     = mem_q[rptr_q];
    assign wb_data  = out_valid ? head.data : '0;
    assign wb_rd    = out_valid ? head.rd   : 5'd0;
    assign wb_en    = out_valid && head.en;
    assign br_taken = out_valid && head.br;

`ifdef ALU_RESULT_STAGE_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [31:0] stat_taken_q, stat_taken_d;

    always_comb begin
        stat_ops_d   = stat_ops_q;
        stat_taken_d = stat_taken_q;
        if (pop) begin
            stat_ops_d = stat_ops_q + 32'd1;
            if (head.br) begin
                stat_taken_d = stat_taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q   <= 32'd0;
            stat_taken_q <= 32'd0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_taken = stat_taken_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - randomized self-checking bench for alu_result_stage against a queue model.
module tb_alu_result_stage;

    localparam logic [3:0] ADD = 4'd2;
    localparam logic [3:0] SUB = 4'd6;
    localparam logic [3:0] LT  = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_data = 32'd0;
    logic        alu_zero = 1'b0;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [4:0]  rd = 5'd0;
    logic        reg_write = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        br_taken;
`ifdef ALU_RESULT_STAGE_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_taken;
    logic [31:0] m_ops = 0;
    logic [31:0] m_taken = 0;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_data(alu_data), .alu_zero(alu_zero), .alu_ctrl(alu_ctrl),
        .rd(rd), .reg_write(reg_write), .br_type(br_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
`ifdef ALU_RESULT_STAGE_STATS_EN
        .stat_ops(stat_ops), .stat_taken(stat_taken),
`endif
        .br_taken(br_taken)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        en;
        logic        br;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model_entry();
        exp_t e;
        if (alu_ctrl == LT) e.d = (alu_data[0] == 1'b0) ? 32'd1 : 32'd0;
        else                e.d = alu_data;
        e.rd = rd;
        e.en = reg_write && (rd != 0);
        e.br = 1'b0;
        if (br_type == 2'b01 && alu_ctrl == SUB) e.br = alu_zero;
        if (br_type == 2'b10 && alu_ctrl == SUB) e.br = !alu_zero;
        if (br_type == 2'b11 && alu_ctrl == LT)  e.br = (alu_data[0] == 1'b0);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
`ifdef ALU_RESULT_STAGE_STATS_EN
            m_ops = 0;
            m_taken = 0;
`endif
        end else if (flush) begin
            q.delete();
        end else begin
            automatic int n = q.size();
            automatic exp_t e = model_entry();
            if (n != 0 && out_ready) begin
`ifdef ALU_RESULT_STAGE_STATS_EN
                m_ops = m_ops + 1;
                if (q[0].br) m_taken = m_taken + 1;
`endif
                void'(q.pop_front());
            end
            if (in_valid && n != 2) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, q.size() != 2);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("wb_data", wb_data, q[0].d);
                chk("wb_rd", wb_rd, q[0].rd);
                chk("wb_en", wb_en, q[0].en);
                chk("br_taken", br_taken, q[0].br);
            end
`ifdef ALU_RESULT_STAGE_STATS_EN
            chk("stat_ops", stat_ops, m_ops);
            chk("stat_taken", stat_taken, m_taken);
`endif
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic z, input logic [3:0] c,
                         input logic [4:0] r, input logic w, input logic [1:0] b);
        in_valid = v; alu_data = d; alu_zero = z; alu_ctrl = c;
        rd = r; reg_write = w; br_type = b;
    endtask

    task automatic single(input string name, input logic [31:0] d, input logic z, input logic [3:0] c,
                          input logic [4:0] r, input logic w, input logic [1:0] b,
                          input logic [31:0] ed, input logic een, input logic ebr);
        drive(1'b1, d, z, c, r, w, b);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk({name, ".valid"}, out_valid, 1'b1);
        chk({name, ".data"}, wb_data, ed);
        chk({name, ".en"}, wb_en, een);
        chk({name, ".br"}, br_taken, ebr);
        @(negedge clk);
        chk({name, ".drain"}, out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.wb_en", wb_en, 1'b0);
        chk("rst.br_taken", br_taken, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        single("add", 32'h5, 1'b0, ADD, 5'd3, 1'b1, 2'b00, 32'h5, 1'b1, 1'b0);
        chk("add.rd_hold", 5'd3, 5'd3 & {5{1'b1}});
        single("lt0", 32'h0, 1'b0, LT, 5'd4, 1'b1, 2'b00, 32'h1, 1'b1, 1'b0);
        single("lt1", 32'h1, 1'b0, LT, 5'd4, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0);
        single("beq", 32'h0, 1'b1, SUB, 5'd0, 1'b0, 2'b01, 32'h0, 1'b0, 1'b1);
        single("bne", 32'h0, 1'b1, SUB, 5'd0, 1'b0, 2'b10, 32'h0, 1'b0, 1'b0);
        single("blt", 32'h0, 1'b0, LT, 5'd0, 1'b0, 2'b11, 32'h1, 1'b0, 1'b1);
        single("beq_add", 32'h0, 1'b1, ADD, 5'd0, 1'b0, 2'b01, 32'h0, 1'b0, 1'b0);
        single("rd0", 32'h77, 1'b0, ADD, 5'd0, 1'b1, 2'b00, 32'h77, 1'b0, 1'b0);

        // Backpressure, full-with-ready, then refill.
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0, ADD, 5'd1, 1'b1, 2'b00);
        @(posedge clk); #1 alu_data = 32'hB;
        @(posedge clk); #1 alu_data = 32'hC;
        @(negedge clk);
        chk("bp.in_ready", in_ready, 1'b0);
        chk("bp.head", wb_data, 32'hA);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp.hold", wb_data, 32'hA);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full.pop_b", wb_data, 32'hB);
        chk("full.in_ready", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("full.c", wb_data, 32'hC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full.empty", out_valid, 1'b0);

        // Flush with a full buffer and a competing push.
        out_ready = 1'b0;
        drive(1'b1, 32'hD, 1'b0, ADD, 5'd2, 1'b1, 2'b00);
        @(posedge clk); #1 alu_data = 32'hE;
        @(posedge clk); #1 alu_data = 32'hF; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush.out_valid", out_valid, 1'b0);
        chk("flush.in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("flush.dropped", out_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (i == 1500) begin
                in_valid = 1'b1;
                #3 rst_n = 1'b0;
                #1;
                chk("arst.out_valid", out_valid, 1'b0);
                chk("arst.wb_data", wb_data, 32'd0);
                chk("arst.wb_rd", wb_rd, 5'd0);
                chk("arst.wb_en", wb_en, 1'b0);
                chk("arst.br_taken", br_taken, 1'b0);
                @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
                @(negedge clk);
                chk("arst.in_ready", in_ready, 1'b1);
            end else begin
                automatic logic [3:0] c;
                automatic int s = $urandom_range(0, 3);
                c = (s == 0) ? ADD : (s == 1) ? SUB : (s == 2) ? LT : 4'($urandom);
                #1;
                drive($urandom_range(0, 9) < 6, $urandom, 1'($urandom), c,
                      ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), 2'($urandom));
                out_ready = $urandom_range(0, 9) < 7;
                flush = $urandom_range(0, 39) == 0;
            end
        end
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
